// File: rtl/fifo_seq_checker_pkg.sv
// Shared encodings for the FIFO sequence checker: FSM states and LED bit positions.
package fifo_seq_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_STALL = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    localparam int unsigned LED_RUNNING   = 0;
    localparam int unsigned LED_HEARTBEAT = 1;
    localparam int unsigned LED_ERR       = 2;
    localparam int unsigned LED_TIMEOUT   = 3;

    localparam int unsigned HEARTBEAT_BIT = 20;

endpackage

// File: rtl/fifo_seq_throttle.sv
// Burst/stall pacing for the checker: counts RUN consumes and times the read-stall window.
module fifo_seq_throttle
    import fifo_seq_checker_pkg::*;
#(
    parameter int unsigned BurstLen = 64,
    parameter int unsigned StallLen = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic consume_i,
    input  logic clear_i,
    input  logic abort_i,
    output logic stall_active_c
);

    localparam int unsigned BW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
    localparam int unsigned SW = (StallLen > 1) ? $clog2(StallLen) : 1;

    logic [BW-1:0] burst_q, burst_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          active_q, active_d;

    // stall_active_c is the next-cycle stall flag so the FSM can switch state on the same edge
    always_comb begin
        burst_d  = burst_q;
        stall_d  = stall_q;
        active_d = active_q;
        if (clear_i) begin
            burst_d = '0;
        end
        if (active_q) begin
            if (stall_q == SW'(StallLen - 1)) begin
                active_d = 1'b0;
                stall_d  = '0;
                burst_d  = '0;
            end else begin
                stall_d = stall_q + SW'(1);
            end
        end else if (consume_i && (BurstLen != 0)) begin
            if (burst_q == BW'(BurstLen - 1)) begin
                burst_d  = '0;
                active_d = 1'b1;
            end else begin
                burst_d = burst_q + BW'(1);
            end
        end
        if (abort_i) begin
            active_d = 1'b0;
            stall_d  = '0;
        end
    end

    assign stall_active_c = active_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q  <= '0;
            stall_q  <= '0;
            active_q <= 1'b0;
        end else begin
            burst_q  <= burst_d;
            stall_q  <= stall_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/fifo_seq_checker.sv
// Read-side consumer for the bank FIFO: drains words, checks the +1 sequence,
// paces reads with bursts/stalls, and trips a starvation watchdog.
module fifo_seq_checker
    import fifo_seq_checker_pkg::*;
#(
    parameter int unsigned Width      = 16,
    parameter int unsigned BurstLen   = 64,
    parameter int unsigned StallLen   = 32,
    parameter int unsigned Timeout    = 4096,
    parameter int unsigned CountWidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  trigger,
    input  logic [Width-1:0]      data,
    input  logic                  ok,
    output logic [CountWidth-1:0] wordCount,
    output logic [CountWidth-1:0] errCount,
    output logic [Width-1:0]      firstExp,
    output logic [Width-1:0]      firstGot,
    output logic                  err,
    output logic                  timeout,
    output logic [3:0]            led
);

    localparam int unsigned WDW = $clog2(Timeout + 1);
    localparam int unsigned HB  = (CountWidth > HEARTBEAT_BIT) ? HEARTBEAT_BIT : CountWidth - 1;

    state_e                state_q, state_d;
    logic                  trigger_q, trigger_d;
    logic                  primed_q, primed_d;
    logic [Width-1:0]      prev_q, prev_d;
    logic [Width-1:0]      first_exp_q, first_exp_d;
    logic [Width-1:0]      first_got_q, first_got_d;
    logic [CountWidth-1:0] word_cnt_q, word_cnt_d;
    logic [CountWidth-1:0] err_cnt_q, err_cnt_d;
    logic                  err_q, err_d;
    logic                  timeout_q, timeout_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic [3:0]            led_q, led_d;

    logic                  consume_c;
    logic                  stall_active_c;
    logic [Width-1:0]      exp_c;

    assign consume_c = trigger_q & ok;
    assign exp_c     = prev_q + Width'(1);

    fifo_seq_throttle #(
        .BurstLen (BurstLen),
        .StallLen (StallLen)
    ) u_throttle (
        .clk            (clk),
        .rst            (rst),
        .consume_i      (consume_c && (state_q == ST_RUN)),
        .clear_i        (consume_c && (state_q == ST_PRIME)),
        .abort_i        (!en || !((state_q == ST_RUN) || (state_q == ST_STALL))),
        .stall_active_c (stall_active_c)
    );

    always_comb begin
        state_d     = state_q;
        primed_d    = primed_q;
        prev_d      = prev_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        wd_d        = wd_q;
        led_d       = led_q;

        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (en) begin
                    state_d = primed_q ? ST_RUN : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (consume_c) begin
                    prev_d     = data;
                    primed_d   = 1'b1;
                    word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CountWidth'(1);
                    state_d    = en ? ST_RUN : ST_IDLE;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A word already handed over by the FIFO is checked even if en just dropped
                if (consume_c) begin
                    prev_d     = data;
                    wd_d       = '0;
                    word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CountWidth'(1);
                    if (data != exp_c) begin
                        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CountWidth'(1);
                        err_d     = 1'b1;
                        if (!err_q) begin
                            first_exp_d = exp_c;
                            first_got_d = data;
                        end
                    end
                end
                if (!en) begin
                    state_d = ST_IDLE;
                    wd_d    = '0;
                end else if (!consume_c) begin
                    if (wd_q == WDW'(Timeout - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_FAIL;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end else if (stall_active_c) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                wd_d = '0;
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (!stall_active_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        trigger_d                  = (state_d == ST_PRIME) || (state_d == ST_RUN);
        led_d[LED_TIMEOUT]         = timeout_d;
        led_d[LED_ERR]             = err_d;
        led_d[LED_HEARTBEAT]       = word_cnt_d[HB];
        led_d[LED_RUNNING]         = (state_d != ST_IDLE) && !timeout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            trigger_q   <= 1'b0;
            primed_q    <= 1'b0;
            prev_q      <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            trigger_q   <= trigger_d;
            primed_q    <= primed_d;
            prev_q      <= prev_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
            led_q       <= led_d;
        end
    end

    assign trigger   = trigger_q;
    assign wordCount = word_cnt_q;
    assign errCount  = err_cnt_q;
    assign firstExp  = first_exp_q;
    assign firstGot  = first_got_q;
    assign err       = err_q;
    assign timeout   = timeout_q;
    assign led       = led_q;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Bench for fifo_seq_checker: a FIFO model feeds words, a sequence model fills a scoreboard.
module tb_fifo_seq_checker;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic [CW-1:0] wc;
        logic [CW-1:0] ec;
        logic          err;
    } snap_t;

    logic          clk;
    logic          rst, en, ok, trigger, err, timeout;
    logic [W-1:0]  data, first_exp, first_got;
    logic [CW-1:0] word_count, err_count;
    logic [3:0]    led;

    logic          rst_b, en_b, ok_b, trigger_b, err_b, timeout_b;
    logic [W-1:0]  data_b, first_exp_b, first_got_b;
    logic [CW-1:0] word_count_b, err_count_b;
    logic [3:0]    led_b;

    int total = 0;
    int bad   = 0;

    snap_t        sb_exp[$];
    snap_t        sb_obs[$];
    logic [W-1:0] src_q[$];

    logic          m_primed, m_err;
    logic [W-1:0]  m_prev, m_fexp, m_fgot;
    logic [CW-1:0] m_wc, m_ec;

    fifo_seq_checker #(
        .Width(W), .BurstLen(0), .StallLen(1), .Timeout(16), .CountWidth(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .data(data), .ok(ok),
        .wordCount(word_count), .errCount(err_count), .firstExp(first_exp),
        .firstGot(first_got), .err(err), .timeout(timeout), .led(led)
    );

    fifo_seq_checker #(
        .Width(W), .BurstLen(4), .StallLen(3), .Timeout(4096), .CountWidth(CW)
    ) u_thr (
        .clk(clk), .rst(rst_b), .en(en_b), .trigger(trigger_b), .data(data_b), .ok(ok_b),
        .wordCount(word_count_b), .errCount(err_count_b), .firstExp(first_exp_b),
        .firstGot(first_got_b), .err(err_b), .timeout(timeout_b), .led(led_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        m_primed = 1'b0; m_err = 1'b0; m_prev = '0; m_fexp = '0; m_fgot = '0;
        m_wc = '0; m_ec = '0;
        sb_exp.delete(); sb_obs.delete(); src_q.delete();
    endtask

    task automatic model_consume(input logic [W-1:0] d);
        logic [W-1:0] e;
        snap_t s;
        if (m_primed) begin
            e = m_prev + W'(1);
            if (d != e) begin
                m_ec = m_ec + 1;
                if (!m_err) begin
                    m_fexp = e;
                    m_fgot = d;
                end
                m_err = 1'b1;
            end
        end
        m_primed = 1'b1;
        m_prev   = d;
        m_wc     = m_wc + 1;
        s.wc = m_wc; s.ec = m_ec; s.err = m_err;
        sb_exp.push_back(s);
    endtask

    // One read cycle, entered and left at a falling edge
    task automatic drive_cycle(input logic v_ok, input logic [W-1:0] v_data, output logic consumed);
        snap_t s;
        ok       = v_ok;
        data     = v_data;
        consumed = (trigger === 1'b1) && v_ok;
        if (consumed) model_consume(v_data);
        @(posedge clk);
        #1;
        if (consumed) begin
            s.wc = word_count; s.ec = err_count; s.err = err;
            sb_obs.push_back(s);
        end
        @(negedge clk);
    endtask

    task automatic feed_words(input int bound, output logic stuck);
        logic c;
        for (int i = 0; i < bound && src_q.size() != 0; i++) begin
            drive_cycle(1'b1, src_q[0], c);
            if (c) src_q.delete(0);
        end
        stuck = (src_q.size() != 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1; en = 1'b0; ok = 1'b0; data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (trigger !== 1'b0) begin bad++; $display("FAIL reset_trigger got=%b exp=0", trigger); end
        total++; if ({word_count, err_count} !== '0) begin bad++; $display("FAIL reset_counts got wc=%0d ec=%0d exp 0", word_count, err_count); end
        total++; if ({first_exp, first_got} !== '0) begin bad++; $display("FAIL reset_first got %h/%h exp 0", first_exp, first_got); end
        total++; if ({err, timeout, led} !== 6'b0) begin bad++; $display("FAIL reset_flags got err=%b to=%b led=%b exp 0", err, timeout, led); end
    endtask

    task automatic test_stream();
        localparam int N = 1000;
        logic [W-1:0] w;
        logic c;
        int drops;
        snap_t e, o;
        reset_dut();
        en = 1'b1;
        total++; if (trigger !== 1'b0) begin bad++; $display("FAIL stream_trig_early got=%b exp=0", trigger); end
        drive_cycle(1'b1, '0, c);
        total++; if (trigger !== 1'b1) begin bad++; $display("FAIL stream_trig_latency got=%b exp=1", trigger); end
        w = '0; drops = 0;
        for (int i = 0; i < N; i++) begin
            if (trigger !== 1'b1) drops++;
            drive_cycle(1'b1, w, c);
            if (c) w = w + W'(1);
        end
        while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL stream_sb got wc=%0d ec=%0d err=%b exp wc=%0d ec=%0d err=%b", o.wc, o.ec, o.err, e.wc, e.ec, e.err); end
        end
        total++; if (drops !== 0) begin bad++; $display("FAIL stream_trig_drop got=%0d exp=0", drops); end
        total++; if (word_count !== CW'(N)) begin bad++; $display("FAIL stream_wc got=%0d exp=%0d", word_count, N); end
        total++; if ({err, led[0]} !== 2'b01) begin bad++; $display("FAIL stream_flags got err=%b run=%b exp 0/1", err, led[0]); end
        en = 1'b0;
        drive_cycle(1'b0, '0, c);
        total++; if ({trigger, led[0]} !== 2'b00) begin bad++; $display("FAIL stream_disable got trig=%b run=%b exp 0/0", trigger, led[0]); end
    endtask

    task automatic test_mismatch();
        logic stuck, c;
        snap_t e, o;
        reset_dut();
        en = 1'b1;
        src_q = '{16'h0005, 16'h0006, 16'h0009, 16'h000A};
        feed_words(30, stuck);
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL mis_feed_bound got stuck=%b exp=0", stuck); end
        while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL mis_sb got wc=%0d ec=%0d err=%b exp wc=%0d ec=%0d err=%b", o.wc, o.ec, o.err, e.wc, e.ec, e.err); end
        end
        total++; if (err_count !== 32'd1) begin bad++; $display("FAIL mis_errcount got=%0d exp=1", err_count); end
        total++; if (first_exp !== 16'h0007) begin bad++; $display("FAIL mis_firstexp got=%h exp=0007", first_exp); end
        total++; if (first_got !== 16'h0009) begin bad++; $display("FAIL mis_firstgot got=%h exp=0009", first_got); end
        total++; if ({err, led[2]} !== 2'b11) begin bad++; $display("FAIL mis_err got err=%b led=%b exp 1/1", err, led[2]); end
        en = 1'b0;
        drive_cycle(1'b0, '0, c);
    endtask

    task automatic test_wrap();
        logic stuck, c;
        snap_t e, o;
        reset_dut();
        en = 1'b1;
        src_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        feed_words(30, stuck);
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL wrap_feed_bound got stuck=%b exp=0", stuck); end
        while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL wrap_sb got wc=%0d ec=%0d err=%b exp wc=%0d ec=%0d err=%b", o.wc, o.ec, o.err, e.wc, e.ec, e.err); end
        end
        total++; if ({err, err_count} !== 33'd0) begin bad++; $display("FAIL wrap_err got err=%b ec=%0d exp 0", err, err_count); end
        total++; if (word_count !== 32'd4) begin bad++; $display("FAIL wrap_wc got=%0d exp=4", word_count); end
        en = 1'b0;
        drive_cycle(1'b0, '0, c);
    endtask

    task automatic test_back_to_back_stall();
        logic t_exp;
        logic [CW-1:0] mwc;
        rst_b = 1'b1; en_b = 1'b0; ok_b = 1'b0; data_b = '0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0; en_b = 1'b1; ok_b = 1'b1;
        mwc = '0;
        @(negedge clk);
        for (int i = 0; i < 42; i++) begin
            t_exp = (i == 0) ? 1'b1 : (((i - 1) % 7) < 4);
            total++; if (trigger_b !== t_exp) begin bad++; $display("FAIL stall_trig[%0d] got=%b exp=%b", i, trigger_b, t_exp); end
            data_b = W'(mwc);
            if (t_exp) mwc = mwc + 1;
            @(posedge clk);
            #1;
            @(negedge clk);
            total++; if (word_count_b !== mwc) begin bad++; $display("FAIL stall_wc[%0d] got=%0d exp=%0d", i, word_count_b, mwc); end
        end
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL stall_err got=%b exp=0", err_b); end
        en_b = 1'b0; ok_b = 1'b0;
    endtask

    task automatic test_timeout();
        logic stuck, c, fired;
        int s;
        snap_t e, o;
        reset_dut();
        en = 1'b1;
        for (int i = 0; i < 10; i++) src_q.push_back(W'(i));
        feed_words(40, stuck);
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL to_feed_bound got stuck=%b exp=0", stuck); end
        while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL to_sb got wc=%0d ec=%0d err=%b exp wc=%0d ec=%0d err=%b", o.wc, o.ec, o.err, e.wc, e.ec, e.err); end
        end
        s = 0; fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            if (trigger === 1'b1) s++;
            drive_cycle(1'b0, '0, c);
            if (timeout === 1'b1) fired = 1'b1;
        end
        total++; if (fired !== 1'b1) begin bad++; $display("FAIL to_never_fired got timeout=%b exp=1", timeout); end
        total++; if (s != 16) begin bad++; $display("FAIL to_cycle got=%0d exp=16", s); end
        total++; if ({trigger, led[3], led[0]} !== 3'b010) begin bad++; $display("FAIL to_outputs got trig=%b led3=%b led0=%b exp 0/1/0", trigger, led[3], led[0]); end
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 16'h000A, c);
        total++; if (word_count !== 32'd10) begin bad++; $display("FAIL to_terminal_wc got=%0d exp=10", word_count); end
        total++; if ({trigger, timeout} !== 2'b01) begin bad++; $display("FAIL to_terminal got trig=%b to=%b exp 0/1", trigger, timeout); end
    endtask

    task automatic test_reset_midrun();
        logic stuck, c;
        snap_t e, o;
        reset_dut();
        en = 1'b1;
        src_q = '{16'h0000, 16'h0001, 16'h0005, 16'h0006, 16'h0009};
        feed_words(30, stuck);
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL rmr_feed_bound got stuck=%b exp=0", stuck); end
        while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL rmr_sb got wc=%0d ec=%0d err=%b exp wc=%0d ec=%0d err=%b", o.wc, o.ec, o.err, e.wc, e.ec, e.err); end
        end
        total++; if (err_count !== 32'd2) begin bad++; $display("FAIL rmr_errcount got=%0d exp=2", err_count); end
        rst = 1'b1;
        drive_cycle(1'b0, '0, c);
        total++; if ({trigger, err, timeout, led} !== 7'b0) begin bad++; $display("FAIL rmr_flags got trig=%b err=%b to=%b led=%b exp 0", trigger, err, timeout, led); end
        total++; if ({word_count, err_count, first_exp, first_got} !== '0) begin bad++; $display("FAIL rmr_values got wc=%0d ec=%0d fe=%h fg=%h exp 0", word_count, err_count, first_exp, first_got); end
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 20; i++) src_q.push_back(W'(100 + i));
        feed_words(60, stuck);
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL rmr_feed2_bound got stuck=%b exp=0", stuck); end
        while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL rmr_sb2 got wc=%0d ec=%0d err=%b exp wc=%0d ec=%0d err=%b", o.wc, o.ec, o.err, e.wc, e.ec, e.err); end
        end
        total++; if ({err, err_count} !== 33'd0) begin bad++; $display("FAIL rmr_clean got err=%b ec=%0d exp 0", err, err_count); end
        total++; if (word_count !== 32'd20) begin bad++; $display("FAIL rmr_wc got=%0d exp=20", word_count); end
        en = 1'b0;
        drive_cycle(1'b0, '0, c);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ok = 1'b0; data = '0;
        rst_b = 1'b1; en_b = 1'b0; ok_b = 1'b0; data_b = '0;
        test_reset();
        test_stream();
        test_mismatch();
        test_wrap();
        test_back_to_back_stall();
        test_timeout();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
